// File: rtl/hack_cpu_seq.sv
// Two-state Hack CPU sequencer: FETCH accepts an instruction, EXEC drives
// the external ALU and commits A, D and pc on its exit edge.
module hack_cpu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] inM,
  input  logic [15:0] alu_o,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [15:0] addressM,
  output logic [15:0] pc
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] pc_q, pc_d;
  logic        is_c;
  logic        jump;

  assign is_c = ir_q[15];
  assign jump = (ir_q[2] & alu_ng)
              | (ir_q[1] & alu_zr)
              | (ir_q[0] & ~alu_ng & ~alu_zr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      d_q     <= d_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    a_d         = a_q;
    d_d         = d_q;
    pc_d        = pc_q;
    instr_ready = 1'b0;
    alu_x       = '0;
    alu_y       = '0;
    zx          = 1'b0;
    nx          = 1'b0;
    zy          = 1'b0;
    ny          = 1'b0;
    f           = 1'b0;
    no          = 1'b0;
    writeM      = 1'b0;
    outM        = '0;
    unique case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        if (is_c) begin
          zx     = ir_q[11];
          nx     = ir_q[10];
          zy     = ir_q[9];
          ny     = ir_q[8];
          f      = ir_q[7];
          no     = ir_q[6];
          alu_x  = d_q;
          alu_y  = ir_q[12] ? inM : a_q;
          writeM = ir_q[3];
          outM   = ir_q[3] ? alu_o : 16'h0000;
          if (ir_q[5]) a_d = alu_o;
          if (ir_q[4]) d_d = alu_o;
          // jump target is the A value seen before this instruction
          pc_d = jump ? a_q : pc_q + 16'd1;
        end else begin
          a_d  = {1'b0, ir_q[14:0]};
          pc_d = pc_q + 16'd1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign addressM = a_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Bench for hack_cpu_seq: instruction-level Hack model, per-cycle compare,
// plus directed literal checks on the program sequence.
module tb_hack_cpu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] inM;
  logic [15:0] alu_o;
  logic        alu_zr;
  logic        alu_ng;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] addressM;
  logic [15:0] pc;

  int checks = 0;
  int errors = 0;

  hack_cpu_seq dut (
    .clk(clk), .reset(reset),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .inM(inM), .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .alu_x(alu_x), .alu_y(alu_y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .outM(outM), .writeM(writeM), .addressM(addressM), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    r  = c[1] ? xx + yy : xx & yy;
    r  = c[0] ? ~r : r;
    return r;
  endfunction

  // environment: ALU and a small data memory
  logic [15:0] env_mem [256];
  always_comb alu_o = hack_alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
  assign alu_zr = (alu_o == 16'h0);
  assign alu_ng = alu_o[15];
  assign inM = env_mem[addressM[7:0]];
  always @(posedge clk) if (writeM) env_mem[addressM[7:0]] <= outM;

  // instruction-level reference model
  logic        m_busy = 1'b0;
  logic [15:0] m_ir = 0, m_a = 0, m_d = 0, m_pc = 0;
  logic [15:0] m_mem [256];
  bit          started = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 16'h0;
      m_mem[i]   = 16'h0;
    end
  end

  always @(posedge clk) begin
    logic [15:0] y, r, old_a;
    logic        j;
    if (reset) begin
      started = 1'b1;
      m_busy = 1'b0; m_ir = 0; m_a = 0; m_d = 0; m_pc = 0;
    end else if (!m_busy) begin
      if (instr_valid) begin
        m_ir = instr;
        m_busy = 1'b1;
      end
    end else begin
      m_busy = 1'b0;
      if (!m_ir[15]) begin
        m_a  = {1'b0, m_ir[14:0]};
        m_pc = m_pc + 16'd1;
      end else begin
        y = m_ir[12] ? m_mem[m_a[7:0]] : m_a;
        r = hack_alu(m_d, y, m_ir[11:6]);
        j = (m_ir[2] && $signed(r) < 0) || (m_ir[1] && r == 0)
          || (m_ir[0] && $signed(r) > 0);
        old_a = m_a;
        if (m_ir[3]) m_mem[old_a[7:0]] = r;
        if (m_ir[5]) m_a = r;
        if (m_ir[4]) m_d = r;
        m_pc = j ? old_a : m_pc + 16'd1;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic        ex;
    logic [15:0] ey, er;
    if (started) begin
      ex = m_busy && m_ir[15];
      ey = m_ir[12] ? m_mem[m_a[7:0]] : m_a;
      er = hack_alu(m_d, ey, m_ir[11:6]);
      chk("ready", {15'h0, instr_ready}, {15'h0, !m_busy});
      chk("pc", pc, m_pc);
      chk("addressM", addressM, m_a);
      chk("writeM", {15'h0, writeM}, {15'h0, ex && m_ir[3]});
      chk("outM", outM, (ex && m_ir[3]) ? er : 16'h0);
      chk("ctrl", {10'h0, zx, nx, zy, ny, f, no},
          ex ? {10'h0, m_ir[11:6]} : 16'h0);
      chk("alu_x", alu_x, ex ? m_d : 16'h0);
      chk("alu_y", alu_y, ex ? ey : 16'h0);
    end
  end

  // snapshot of the EXEC cycle of the last issued instruction
  logic        s_ready, s_wm;
  logic [15:0] s_am, s_om, s_x, s_y;
  logic [5:0]  s_ctl;

  task automatic issue(input logic [15:0] w);
    int n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    if (!instr_ready) chk("ready_timeout", 16'h0, 16'h1);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    s_ready = instr_ready; s_wm = writeM; s_am = addressM;
    s_om = outM; s_x = alu_x; s_y = alu_y;
    s_ctl = {zx, nx, zy, ny, f, no};
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; instr = 0; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 16'h0);
    chk("rst_ready", {15'h0, instr_ready}, 16'h1);
    chk("rst_addr", addressM, 16'h0);
    @(posedge clk); #1;

    issue(16'h0010);
    chk("a16_ready_exec", {15'h0, s_ready}, 16'h0);
    chk("a16_wm", {15'h0, s_wm}, 16'h0);
    chk("a16_A", addressM, 16'd16);
    chk("a16_pc", pc, 16'd1);

    issue(16'hEC10);
    chk("dA_ctl", {10'h0, s_ctl}, 16'b110000);
    chk("dA_y", s_y, 16'd16);
    chk("dA_pc", pc, 16'd2);

    issue(16'h000F);
    issue(16'hE090);
    chk("dpa_x", s_x, 16'd16);
    chk("dpa_y", s_y, 16'd15);
    issue(16'hE308);
    chk("mD_wm", {15'h0, s_wm}, 16'h1);
    chk("mD_addr", s_am, 16'd15);
    chk("mD_out", s_om, 16'd31);
    chk("mD_pc", pc, 16'd5);

    issue(16'h0007);
    issue(16'hE301);
    chk("jgt_pc", pc, 16'd7);
    issue(16'h0003);
    issue(16'hE302);
    chk("jeq_pc", pc, 16'd9);

    repeat (5) @(posedge clk);
    #1;
    chk("idle_pc", pc, 16'd9);
    chk("idle_A", addressM, 16'd3);
    chk("idle_ready", {15'h0, instr_ready}, 16'h1);

    issue(16'hEEA0);
    chk("neg1_x", s_x, 16'd31);
    chk("neg1_A", addressM, 16'hFFFF);
    issue(16'hEA87);
    chk("jmp_pc", pc, 16'hFFFF);
    issue(16'h0001);
    chk("wrap_pc", pc, 16'h0000);
    chk("wrap_A", addressM, 16'h0001);

    issue(16'h000F);
    instr = 16'hE308; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_wm_before", {15'h0, writeM}, 16'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_wm", {15'h0, writeM}, 16'h0);
    chk("abort_pc", pc, 16'h0);
    chk("abort_A", addressM, 16'h0);
    chk("abort_ready", {15'h0, instr_ready}, 16'h1);
    @(posedge clk); #1;
    issue(16'hE308);
    chk("abort_D", s_x, 16'h0);
    chk("abort_out", s_om, 16'h0);

    instr = 16'h0005; instr_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    chk("rstpri_ready", {15'h0, instr_ready}, 16'h1);
    chk("rstpri_A", addressM, 16'h0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_cpu_seq.md
HACK_CPU_SEQ -- requirements
Module: hack_cpu_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  16  instruction word, sampled on the accepting edge.
REQ-005 instr_valid  input  1  instr holds a valid instruction.
REQ-006 instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 inM  input  16  data-memory read value for the address on addressM.
REQ-008 alu_o  input  16  result from the downstream 16-bit ALU.
REQ-009 alu_zr  input  1  ALU zero flag.
REQ-010 alu_ng  input  1  ALU negative flag.
REQ-011 alu_x  output  16  ALU x operand.
REQ-012 alu_y  output  16  ALU y operand.
REQ-013 zx, nx, zy, ny, f, no  output  1 each  ALU control bits.
REQ-014 outM  output  16  data-memory write value.
REQ-015 writeM  output  1  data-memory write strobe.
REQ-016 addressM  output  16  data-memory address.
REQ-017 pc  output  16  program counter, which is the address of the next instruction.

Function
REQ-018 The FSM SHALL have exactly two states, FETCH and EXEC.
REQ-019 instr_ready SHALL be 1 only in FETCH.
REQ-020 In FETCH with instr_valid=1, the block SHALL latch instr into IR and go to EXEC on the next edge.
REQ-021 In FETCH with instr_valid=0, the block SHALL stay in FETCH and leave all registers unchanged.
REQ-022 EXEC SHALL last exactly one cycle and then return to FETCH.
  - Instruction latency is two cycles when instr_valid is held high.
REQ-023 IR[15]=0 (A-instruction): on the EXEC exit edge the block SHALL load A with {1'b0, IR[14:0]} and set pc to pc+1.
  - writeM SHALL stay 0.
REQ-024 IR[15]=1 (C-instruction): IR[14:13] SHALL be ignored.
REQ-025 In EXEC, the ALU control bits SHALL be driven from IR as follows.
  - zx=IR[11], nx=IR[10], zy=IR[9], ny=IR[8], f=IR[7], no=IR[6].
  - alu_x = D.
  - alu_y = inM when IR[12]=1, otherwise A.
REQ-026 Outside EXEC, and in EXEC for an A-instruction, the control bits SHALL be 0 and alu_x and alu_y SHALL be 0.
REQ-027 On the EXEC exit edge of a C-instruction, the destination bits SHALL be applied as follows.
  - IR[5]=1: A <= alu_o.
  - IR[4]=1: D <= alu_o.
REQ-028 writeM SHALL equal IR[3] during the EXEC cycle of a C-instruction and 0 at all other times.
  - outM = alu_o.
  - addressM = the pre-update value of A.
REQ-029 addressM SHALL equal A in every state.
REQ-030 outM SHALL be 0 whenever writeM=0.
REQ-031 The jump condition SHALL be (IR[2] & alu_ng) | (IR[1] & alu_zr) | (IR[0] & ~alu_ng & ~alu_zr).
REQ-032 If the jump condition is true on the EXEC exit edge, pc SHALL load the pre-update value of A.
  - Otherwise pc SHALL load pc+1.
REQ-033 When IR[5]=1 and the jump is taken in the same instruction, the jump target SHALL be the old A and the new A SHALL be alu_o.
REQ-034 pc+1 SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-035 All arithmetic SHALL be 16-bit modulo 2^16.
REQ-036 A and D SHALL hold their values unless they are explicitly written.

Reset
REQ-037 When reset=1 on a rising edge, the next state SHALL be: FETCH, pc=0, A=0, D=0, IR=0.
REQ-038 When reset=1 during EXEC, the instruction SHALL be aborted with no A, D or pc update.
  - writeM SHALL be 0 from the cycle after that edge.
REQ-039 reset SHALL take priority over instr_valid on the same edge, and the offered instruction SHALL NOT be accepted.
REQ-040 After reset, the outputs SHALL be: instr_ready=1, writeM=0, pc=0, addressM=0, outM=0, all ALU controls 0.

Verification
REQ-041 Reset, then offer 0x0010 -> instr_ready drops for 1 cycle; afterwards A=16, pc=1, writeM never 1.
REQ-042 Continue with 0xEC10 (D=A) -> in EXEC zx..no=110000 and alu_y=16; afterwards D=16, pc=2.
REQ-043 Continue with 0x000F, then 0xE090 (D=D+A), then 0xE308 (M=D).
  - Final EXEC: writeM=1, addressM=15, outM=31.
  - pc=5 afterwards.
REQ-044 With D=31: @7 then 0xE301 (D;JGT) -> pc=7. Then @3 and 0xE302 (D;JEQ) -> not taken, pc=pc+1.
REQ-045 Hold instr_valid=0 for 5 cycles -> state, pc, A and D unchanged. Then set pc=0xFFFF via jump and issue an A-instruction -> pc wraps to 0x0000.
REQ-046 Assert reset during the EXEC of 0xE308 -> writeM low from the next cycle; D, A and pc=0; FETCH entered.
